// File: rtl/pong_pkg.sv
// Shared types and helpers for the Pong round controller: state and winner encodings,
// score saturation limit.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_PAUSE = 3'd4,
        ST_OVER  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_e;

    localparam logic [3:0] SCORE_MAX = 4'd9;

    function automatic logic [3:0] score_inc(input logic [3:0] s);
        return (s >= SCORE_MAX) ? s : s + 4'd1;
    endfunction

    function automatic winner_e winner_of(input logic [3:0] s1, input logic [3:0] s2);
        if (s1 > s2) begin
            return WIN_P1;
        end else if (s2 > s1) begin
            return WIN_P2;
        end
        return WIN_DRAW;
    endfunction

endpackage

// File: rtl/sec_hold_counter.sv
// Seconds hold counter shared by the serve countdown, point hold and match-over hold.
// load wins over tick, so a tick arriving with the load is never counted.
module sec_hold_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] value,
    input  logic       tick,
    output logic       done,
    output logic [3:0] count
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (tick && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // done does not look at load, which keeps the controller's load logic loop-free
    assign done  = tick && (count_q == 4'd1);
    assign count = count_q;

endmodule

// File: rtl/match_sequencer.sv
// Round-level controller for the Pong datapath: serve countdown, rally, point hold, pause
// and match end. Optional macro DEUCE_RULE_EN adds the win-by-two rule (9 always wins).
module match_sequencer #(
    parameter int WIN_SCORE = 7,
    parameter int SERVE_SEC = 3,
    parameter int POINT_SEC = 2,
    parameter int OVER_SEC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       pause_btn,
    input  logic       miss1,
    input  logic       miss2,
    input  logic       timer_zero,
    output logic       stop,
    output logic       launch,
    output logic       serve_side,
    output logic [3:0] countdown,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner,
    output logic [2:0] state
);
    import pong_pkg::*;

    localparam logic [3:0] WIN_S   = 4'(WIN_SCORE);
    localparam logic [3:0] SERVE_S = 4'(SERVE_SEC);
    localparam logic [3:0] POINT_S = 4'(POINT_SEC);
    localparam logic [3:0] OVER_S  = 4'(OVER_SEC);

    state_e     state_q, state_d;
    logic       saved_serve_q, saved_serve_d;
    winner_e    scorer_q, scorer_d;
    winner_e    winner_q, winner_d;
    logic       stop_q, stop_d;
    logic       launch_q, launch_d;
    logic       serve_side_q, serve_side_d;
    logic [3:0] countdown_q, countdown_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;

    logic       cnt_load;
    logic [3:0] cnt_value;
    logic       cnt_tick;
    logic       cnt_done;
    logic [3:0] cnt_count;
    logic [3:0] scorer_pts;
    logic       scorer_won;

    // Ticks only reach the counter in held states; a pause press in SERVE takes priority
    assign cnt_tick = tick_1hz && (((state_q == ST_SERVE) && !pause_btn) ||
                                   (state_q == ST_POINT) || (state_q == ST_OVER));

    sec_hold_counter u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .value (cnt_value),
        .tick  (cnt_tick),
        .done  (cnt_done),
        .count (cnt_count)
    );

`ifdef DEUCE_RULE_EN
    logic [3:0] other_pts;
`endif

    always_comb begin
        scorer_pts = (scorer_q == WIN_P1) ? score1_q : score2_q;
`ifdef DEUCE_RULE_EN
        other_pts  = (scorer_q == WIN_P1) ? score2_q : score1_q;
        scorer_won = (scorer_q != WIN_NONE) &&
                     ((scorer_pts == SCORE_MAX) ||
                      ((scorer_pts >= WIN_S) &&
                       ({1'b0, scorer_pts} >= ({1'b0, other_pts} + 5'd2))));
`else
        scorer_won = (scorer_q != WIN_NONE) && (scorer_pts >= WIN_S);
`endif
    end

    always_comb begin
        state_d       = state_q;
        saved_serve_d = saved_serve_q;
        scorer_d      = scorer_q;
        winner_d      = winner_q;
        launch_d      = 1'b0;
        serve_side_d  = serve_side_q;
        countdown_d   = countdown_q;
        score1_d      = score1_q;
        score2_d      = score2_q;
        cnt_load      = 1'b0;
        cnt_value     = SERVE_S;

        case (state_q)
            ST_IDLE: begin
                score1_d = 4'd0;
                score2_d = 4'd0;
                winner_d = WIN_NONE;
                if (start) begin
                    state_d      = ST_SERVE;
                    countdown_d  = SERVE_S;
                    serve_side_d = 1'b0;
                    cnt_load     = 1'b1;
                    cnt_value    = SERVE_S;
                end
            end
            ST_SERVE: begin
                if (pause_btn) begin
                    state_d       = ST_PAUSE;
                    saved_serve_d = 1'b1;
                end else if (cnt_done) begin
                    state_d     = ST_PLAY;
                    launch_d    = 1'b1;
                    countdown_d = 4'd0;
                end else if (tick_1hz) begin
                    countdown_d = cnt_count - 4'd1;
                end
            end
            ST_PLAY: begin
                if (timer_zero) begin
                    state_d   = ST_OVER;
                    winner_d  = winner_of(score1_q, score2_q);
                    cnt_load  = 1'b1;
                    cnt_value = OVER_S;
                end else if (pause_btn) begin
                    state_d       = ST_PAUSE;
                    saved_serve_d = 1'b0;
                end else if (miss1 || miss2) begin
                    state_d   = ST_POINT;
                    cnt_load  = 1'b1;
                    cnt_value = POINT_S;
                    scorer_d  = WIN_NONE;
                    if (miss1 && !miss2) begin
                        score2_d     = score_inc(score2_q);
                        serve_side_d = 1'b0;
                        scorer_d     = WIN_P2;
                    end else if (miss2 && !miss1) begin
                        score1_d     = score_inc(score1_q);
                        serve_side_d = 1'b1;
                        scorer_d     = WIN_P1;
                    end
                end
            end
            ST_POINT: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    if (scorer_won) begin
                        state_d   = ST_OVER;
                        winner_d  = winner_of(score1_q, score2_q);
                        cnt_value = OVER_S;
                    end else begin
                        state_d     = ST_SERVE;
                        countdown_d = SERVE_S;
                        cnt_value   = SERVE_S;
                    end
                end
            end
            ST_PAUSE: begin
                if (pause_btn) begin
                    state_d = saved_serve_q ? ST_SERVE : ST_PLAY;
                end
            end
            ST_OVER: begin
                if (cnt_done) begin
                    state_d      = ST_IDLE;
                    score1_d     = 4'd0;
                    score2_d     = 4'd0;
                    winner_d     = WIN_NONE;
                    serve_side_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        stop_d = (state_d != ST_PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            saved_serve_q <= 1'b0;
            scorer_q      <= WIN_NONE;
            winner_q      <= WIN_NONE;
            stop_q        <= 1'b1;
            launch_q      <= 1'b0;
            serve_side_q  <= 1'b0;
            countdown_q   <= 4'd0;
            score1_q      <= 4'd0;
            score2_q      <= 4'd0;
        end else begin
            state_q       <= state_d;
            saved_serve_q <= saved_serve_d;
            scorer_q      <= scorer_d;
            winner_q      <= winner_d;
            stop_q        <= stop_d;
            launch_q      <= launch_d;
            serve_side_q  <= serve_side_d;
            countdown_q   <= countdown_d;
            score1_q      <= score1_d;
            score2_q      <= score2_d;
        end
    end

    assign stop       = stop_q;
    assign launch     = launch_q;
    assign serve_side = serve_side_q;
    assign countdown  = countdown_q;
    assign score1     = score1_q;
    assign score2     = score2_q;
    assign winner     = winner_q;
    assign state      = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer: a vector table plus hand-written match sequences,
// with expected outputs queued on drive and compared one cycle later.
module tb_match_sequencer;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    // input vector bits: {rst, tick, start, pause, miss1, miss2, timer_zero}
    localparam logic [6:0] I_NONE  = 7'b0000000;
    localparam logic [6:0] I_RST   = 7'b1000000;
    localparam logic [6:0] I_TICK  = 7'b0100000;
    localparam logic [6:0] I_START = 7'b0010000;
    localparam logic [6:0] I_PAUSE = 7'b0001000;
    localparam logic [6:0] I_M1    = 7'b0000100;
    localparam logic [6:0] I_M2    = 7'b0000010;
    localparam logic [6:0] I_TZ    = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, start, pause_btn, miss1, miss2, timer_zero;
    logic       stop, launch, serve_side;
    logic [3:0] countdown, score1, score2;
    logic [1:0] winner;
    logic [2:0] state;

    always #5 clk = ~clk;

    match_sequencer #(
        .WIN_SCORE (7),
        .SERVE_SEC (3),
        .POINT_SEC (2),
        .OVER_SEC  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .start      (start),
        .pause_btn  (pause_btn),
        .miss1      (miss1),
        .miss2      (miss2),
        .timer_zero (timer_zero),
        .stop       (stop),
        .launch     (launch),
        .serve_side (serve_side),
        .countdown  (countdown),
        .score1     (score1),
        .score2     (score2),
        .winner     (winner),
        .state      (state)
    );

    typedef struct {
        logic [6:0]  in;
        logic [19:0] exp;
    } vec_t;

    vec_t        tbl[38];
    logic [19:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  m_s1, m_s2;
    logic        m_side;

    // expected outputs packed as {state, stop, launch, side, countdown, score1, score2, winner}
    function automatic logic [19:0] ex(input logic [2:0] st, input logic stp, input logic l,
                                       input logic sd, input logic [3:0] cd, input logic [3:0] a,
                                       input logic [3:0] b, input logic [1:0] w);
        return {st, stp, l, sd, cd, a, b, w};
    endfunction

    function automatic logic [3:0] sat(input logic [3:0] s);
        return (s >= 4'd9) ? s : s + 4'd1;
    endfunction

    function automatic logic [1:0] model_winner();
        if (m_s1 > m_s2) return 2'b01;
        if (m_s2 > m_s1) return 2'b10;
        return 2'b11;
    endfunction

    task automatic apply(input logic [6:0] in, input logic [19:0] e, input string nm);
        logic [19:0] got;
        logic [19:0] want;
        logic [19:0] care;
        {rst, tick_1hz, start, pause_btn, miss1, miss2, timer_zero} = in;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = {state, stop, launch, serve_side, countdown, score1, score2, winner};
        want = exp_q.pop_front();
        // countdown while paused is not a defined output, so it is left unchecked there
        care = (want[19:17] == S_PAUSE) ? 20'hFC3FF : 20'hFFFFF;
        n_vec++;
        if ((got & care) !== (want & care)) begin
            n_err++;
            $display("FAIL %s: got st=%0d stop=%0b launch=%0b side=%0b cd=%0d sc=%0d-%0d win=%0d, want st=%0d stop=%0b launch=%0b side=%0b cd=%0d sc=%0d-%0d win=%0d",
                     nm, got[19:17], got[16], got[15], got[14], got[13:10], got[9:6], got[5:2], got[1:0],
                     want[19:17], want[16], want[15], want[14], want[13:10], want[9:6], want[5:2], want[1:0]);
        end else begin
            $display("ok   %s: st=%0d stop=%0b launch=%0b side=%0b cd=%0d sc=%0d-%0d win=%0d",
                     nm, got[19:17], got[16], got[15], got[14], got[13:10], got[9:6], got[5:2], got[1:0]);
        end
    endtask

    task automatic begin_match(input string nm);
        m_s1 = 4'd0;
        m_s2 = 4'd0;
        m_side = 1'b0;
        apply(I_RST, ex(S_IDLE, 1, 0, 0, 0, 0, 0, 0), {nm, " reset"});
        apply(I_START, ex(S_SERVE, 1, 0, 0, 3, 0, 0, 0), {nm, " start"});
    endtask

    task automatic serve_phase(input string nm);
        apply(I_TICK, ex(S_SERVE, 1, 0, m_side, 2, m_s1, m_s2, 0), {nm, " serve cd2"});
        apply(I_TICK, ex(S_SERVE, 1, 0, m_side, 1, m_s1, m_s2, 0), {nm, " serve cd1"});
        apply(I_TICK, ex(S_PLAY, 0, 1, m_side, 0, m_s1, m_s2, 0), {nm, " launch"});
    endtask

    task automatic miss(input logic [6:0] in, input string nm);
        if (in[2] && !in[1]) begin
            m_s2 = sat(m_s2);
            m_side = 1'b0;
        end else if (in[1] && !in[2]) begin
            m_s1 = sat(m_s1);
            m_side = 1'b1;
        end
        apply(in, ex(S_POINT, 1, 0, m_side, 0, m_s1, m_s2, 0), {nm, " miss"});
    endtask

    task automatic hold(input logic to_over, input string nm);
        apply(I_TICK, ex(S_POINT, 1, 0, m_side, 0, m_s1, m_s2, 0), {nm, " hold"});
        if (to_over) begin
            apply(I_TICK, ex(S_OVER, 1, 0, m_side, 0, m_s1, m_s2, model_winner()), {nm, " over"});
        end else begin
            apply(I_TICK, ex(S_SERVE, 1, 0, m_side, 3, m_s1, m_s2, 0), {nm, " reserve"});
        end
    endtask

    task automatic point(input logic [6:0] in, input string nm);
        serve_phase(nm);
        miss(in, nm);
        hold(1'b0, nm);
    endtask

    task automatic finish_over(input string nm);
        apply(I_TICK, ex(S_OVER, 1, 0, m_side, 0, m_s1, m_s2, model_winner()), {nm, " over hold"});
        apply(I_TICK, ex(S_IDLE, 1, 0, 0, 0, 0, 0, 0), {nm, " back to idle"});
    endtask

    initial begin
        tbl[0]  = '{I_RST,          ex(S_IDLE,  1, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{I_NONE,         ex(S_IDLE,  1, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{I_PAUSE,        ex(S_IDLE,  1, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{I_TICK | I_M1,  ex(S_IDLE,  1, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{I_START,        ex(S_SERVE, 1, 0, 0, 3, 0, 0, 0)};
        tbl[5]  = '{I_START,        ex(S_SERVE, 1, 0, 0, 3, 0, 0, 0)};
        tbl[6]  = '{I_TICK,         ex(S_SERVE, 1, 0, 0, 2, 0, 0, 0)};
        tbl[7]  = '{I_NONE,         ex(S_SERVE, 1, 0, 0, 2, 0, 0, 0)};
        tbl[8]  = '{I_TICK,         ex(S_SERVE, 1, 0, 0, 1, 0, 0, 0)};
        tbl[9]  = '{I_TICK,         ex(S_PLAY,  0, 1, 0, 0, 0, 0, 0)};
        tbl[10] = '{I_NONE,         ex(S_PLAY,  0, 0, 0, 0, 0, 0, 0)};
        tbl[11] = '{I_M1 | I_TICK,  ex(S_POINT, 1, 0, 0, 0, 0, 1, 0)};
        tbl[12] = '{I_TICK,         ex(S_POINT, 1, 0, 0, 0, 0, 1, 0)};
        tbl[13] = '{I_TICK,         ex(S_SERVE, 1, 0, 0, 3, 0, 1, 0)};
        tbl[14] = '{I_TICK,         ex(S_SERVE, 1, 0, 0, 2, 0, 1, 0)};
        tbl[15] = '{I_TICK,         ex(S_SERVE, 1, 0, 0, 1, 0, 1, 0)};
        tbl[16] = '{I_TICK,         ex(S_PLAY,  0, 1, 0, 0, 0, 1, 0)};
        tbl[17] = '{I_M2,           ex(S_POINT, 1, 0, 1, 0, 1, 1, 0)};
        tbl[18] = '{I_TICK,         ex(S_POINT, 1, 0, 1, 0, 1, 1, 0)};
        tbl[19] = '{I_TICK,         ex(S_SERVE, 1, 0, 1, 3, 1, 1, 0)};
        tbl[20] = '{I_TICK,         ex(S_SERVE, 1, 0, 1, 2, 1, 1, 0)};
        tbl[21] = '{I_PAUSE,        ex(S_PAUSE, 1, 0, 1, 2, 1, 1, 0)};
        tbl[22] = '{I_TICK,         ex(S_PAUSE, 1, 0, 1, 2, 1, 1, 0)};
        tbl[23] = '{I_TICK | I_M1,  ex(S_PAUSE, 1, 0, 1, 2, 1, 1, 0)};
        tbl[24] = '{I_TICK | I_TZ,  ex(S_PAUSE, 1, 0, 1, 2, 1, 1, 0)};
        tbl[25] = '{I_TICK | I_M2,  ex(S_PAUSE, 1, 0, 1, 2, 1, 1, 0)};
        tbl[26] = '{I_TICK,         ex(S_PAUSE, 1, 0, 1, 2, 1, 1, 0)};
        tbl[27] = '{I_PAUSE,        ex(S_SERVE, 1, 0, 1, 2, 1, 1, 0)};
        tbl[28] = '{I_TICK,         ex(S_SERVE, 1, 0, 1, 1, 1, 1, 0)};
        tbl[29] = '{I_PAUSE|I_TICK, ex(S_PAUSE, 1, 0, 1, 1, 1, 1, 0)};
        tbl[30] = '{I_PAUSE,        ex(S_SERVE, 1, 0, 1, 1, 1, 1, 0)};
        tbl[31] = '{I_TICK,         ex(S_PLAY,  0, 1, 1, 0, 1, 1, 0)};
        tbl[32] = '{I_PAUSE,        ex(S_PAUSE, 1, 0, 1, 0, 1, 1, 0)};
        tbl[33] = '{I_PAUSE,        ex(S_PLAY,  0, 0, 1, 0, 1, 1, 0)};
        tbl[34] = '{I_TZ | I_M1,    ex(S_OVER,  1, 0, 1, 0, 1, 1, 3)};
        tbl[35] = '{I_START|I_TICK, ex(S_OVER,  1, 0, 1, 0, 1, 1, 3)};
        tbl[36] = '{I_PAUSE,        ex(S_OVER,  1, 0, 1, 0, 1, 1, 3)};
        tbl[37] = '{I_TICK,         ex(S_IDLE,  1, 0, 0, 0, 0, 0, 0)};

        for (int i = 0; i < 38; i++) begin
            apply(tbl[i].in, tbl[i].exp, $sformatf("tbl[%0d]", i));
        end

        // reset in the middle of a rally at 3-2
        begin_match("rstmid");
        point(I_M2, "rstmid");
        point(I_M2, "rstmid");
        point(I_M1, "rstmid");
        point(I_M2, "rstmid");
        point(I_M1, "rstmid");
        serve_phase("rstmid");
        apply(I_RST, ex(S_IDLE, 1, 0, 0, 0, 0, 0, 0), "rstmid reset at 3-2");

        // 4-4: double miss replays, then timer expiry beats a simultaneous miss
        begin_match("draw");
        for (int i = 0; i < 4; i++) begin
            point(I_M2, "draw");
            point(I_M1, "draw");
        end
        serve_phase("draw");
        miss(I_M1 | I_M2, "draw replay");
        hold(1'b0, "draw replay");
        serve_phase("draw");
        apply(I_M2 | I_TZ, ex(S_OVER, 1, 0, m_side, 0, 4'd4, 4'd4, 2'b11), "draw timer_zero");
        finish_over("draw");

        // win condition
        begin_match("win");
        for (int i = 0; i < 5; i++) begin
            point(I_M2, "win");
            point(I_M1, "win");
        end
        point(I_M2, "win 6-5");
`ifdef DEUCE_RULE_EN
        point(I_M1, "win 6-6");
        point(I_M2, "win 7-6 no lead");
        serve_phase("win");
        miss(I_M2, "win 8-6");
        hold(1'b1, "win 8-6");
`else
        serve_phase("win");
        miss(I_M2, "win 7-5");
        hold(1'b1, "win 7-5");
`endif
        finish_over("win");

        {rst, tick_1hz, start, pause_btn, miss1, miss2, timer_zero} = I_NONE;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
